// File: rtl/wts_timer_pkg.sv
// wts_timer_pkg: register map, control field layout and shared types for the dual interval timer.
package wts_timer_pkg;

    localparam int CNT_W = 6;

    localparam logic [1:0] ADR_T1_CTRL = 2'd0;
    localparam logic [1:0] ADR_T1_STAT = 2'd1;
    localparam logic [1:0] ADR_T2_CTRL = 2'd2;
    localparam logic [1:0] ADR_T2_STAT = 2'd3;

    localparam int CTRL_EN      = 7;
    localparam int CTRL_ONESHOT = 6;
    localparam int PERIOD_MSB   = 5;
    localparam int PERIOD_LSB   = 0;

    localparam logic [7:0] STATUS_IDLE = 8'h80;

    typedef enum logic [1:0] {
        TMR_IDLE,
        TMR_RUN,
        TMR_EXPIRE
    } tmr_phase_e;

    typedef struct packed {
        logic             en;
        logic             oneshot;
        logic [CNT_W-1:0] period;
    } ctrl_t;

    // Idle status is 80h; pending clears bit7, EN sets bit6.
    function automatic logic [7:0] status_byte(input logic pending, input logic en);
        return STATUS_IDLE ^ {pending, en, 6'b0};
    endfunction

endpackage

// File: rtl/wts_timer_channel.sv
// wts_timer_channel: one programmable interval timer with a read-to-clear expiry flag.
module wts_timer_channel
    import wts_timer_pkg::*;
(
    input  logic       clk,
    input  logic       nreset,
    input  logic       tick,
    input  logic       ctrl_we,
    input  logic [7:0] wdata,
    input  logic       stat_re,
    output logic [7:0] ctrl,
    output logic       pending,
    output logic       en
);

    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pending_q, pending_d;
    tmr_phase_e       phase;
    logic             expire;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ctrl_q    <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    // A control write overrides any tick in the same cycle.
    always_comb begin
        ctrl_d    = ctrl_q;
        count_d   = count_q;
        pending_d = pending_q;
        phase     = !ctrl_q.en ? TMR_IDLE : (tick && count_q == '0) ? TMR_EXPIRE : TMR_RUN;
        expire    = !ctrl_we && phase == TMR_EXPIRE;
        if (ctrl_we) begin
            ctrl_d.en      = wdata[CTRL_EN];
            ctrl_d.oneshot = wdata[CTRL_ONESHOT];
            ctrl_d.period  = wdata[PERIOD_MSB:PERIOD_LSB];
            count_d        = wdata[PERIOD_MSB:PERIOD_LSB];
        end else if (tick && phase == TMR_RUN) begin
            count_d = count_q - CNT_W'(1);
        end else if (expire) begin
            ctrl_d.en = ~ctrl_q.oneshot;
            count_d   = ctrl_q.oneshot ? count_q : ctrl_q.period;
        end
        // Expiry beats a same-cycle status read so no event is lost.
        pending_d = expire ? 1'b1 : stat_re ? 1'b0 : pending_q;
    end

    assign ctrl    = ctrl_q;
    assign pending = pending_q;
    assign en      = ctrl_q.en;

endmodule

// File: rtl/wts_timer.sv
// wts_timer: dual interval timer with register decode, registered read data and aggregated /INT.
module wts_timer
    import wts_timer_pkg::*;
(
    input  logic       clk,
    input  logic       nreset,
    input  logic       tick,
    input  logic       wr,
    input  logic       rd,
    input  logic [1:0] address,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       nint
);

    logic [7:0] ctrl1, ctrl2, rd_mux;
    logic       p1, p2, en1, en2;
    logic [7:0] rdata_q, rdata_d;
    logic       nint_q, nint_d;

    wts_timer_channel u_t1 (
        .clk     (clk),
        .nreset  (nreset),
        .tick    (tick),
        .ctrl_we (wr && address == ADR_T1_CTRL),
        .wdata   (wdata),
        .stat_re (rd && address == ADR_T1_STAT),
        .ctrl    (ctrl1),
        .pending (p1),
        .en      (en1)
    );

    wts_timer_channel u_t2 (
        .clk     (clk),
        .nreset  (nreset),
        .tick    (tick),
        .ctrl_we (wr && address == ADR_T2_CTRL),
        .wdata   (wdata),
        .stat_re (rd && address == ADR_T2_STAT),
        .ctrl    (ctrl2),
        .pending (p2),
        .en      (en2)
    );

    always_comb begin
        rd_mux  = address == ADR_T1_CTRL ? ctrl1 :
                  address == ADR_T1_STAT ? status_byte(p1, en1) :
                  address == ADR_T2_CTRL ? ctrl2 :
                  status_byte(p2, en2);
        rdata_d = rd ? rd_mux : rdata_q;
        nint_d  = ~(p1 | p2);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rdata_q <= 8'h00;
            nint_q  <= 1'b1;
        end else begin
            rdata_q <= rdata_d;
            nint_q  <= nint_d;
        end
    end

    assign rdata = rdata_q;
    assign nint  = nint_q;

endmodule

// File: doc/wts_timer.md
# wts_timer

Dual programmable interval timer with interrupt aggregation for the wave table sound cartridge. It decodes four register offsets (timer 1 control/status, timer 2 control/status) that the top-level slot decoder forwards from the AEF0h–AEF3h window. It counts prescaler ticks, latches expiry flags that are cleared when read, and drives the cartridge /INT request.

## Interface
- No parameters; counter width and bit fields are fixed in wts_timer_pkg.
- clk  in  1  system clock, 21.47727 MHz
- nreset  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle timebase enable from the prescaler
- wr  in  1  one-cycle register write strobe
- rd  in  1  one-cycle register read strobe
- address  in  2  0 = T1 control, 1 = T1 status, 2 = T2 control, 3 = T2 status
- wdata  in  8  write data
- rdata  out  8  registered read data
- nint  out  1  active-low interrupt request, registered; the top level converts it to open-collector (0 → drive low, 1 → Hi-Z)

## Operation
- Control byte (write to address 0 or 2):
  - bit7 EN
  - bit6 ONESHOT
  - bits5:0 PERIOD (0–63)
- A control write latches all three fields and loads the counter with PERIOD. It does not touch the pending flag.
- Writes to addresses 1 and 3 are ignored.
- Each timer has three states: IDLE (EN=0), RUN, EXPIRE. The EXPIRE step happens on a tick.
- On a tick in RUN:
  - If count ≠ 0: count decrements.
  - If count = 0: pending ← 1. If ONESHOT, EN ← 0 (back to IDLE). Otherwise count ← PERIOD.
  - Expiry therefore occurs on the (PERIOD+1)-th tick after the control write.
- While EN=0, ticks are ignored and the count holds.
- Status byte (read address 1 or 3):
  - bit7 = ~pending
  - bit6 = EN
  - bits5:0 = 0
  - Default (idle, nothing pending) reads 80h. An expired one-shot reads 00h.
- Reading a status address clears that timer's pending flag at the same edge. rdata carries the pre-clear value.
- Reading a control address returns the latched control byte and has no side effect.
- nint = ~(pending1 | pending2).

## Timing
- Reset values:
  - EN, ONESHOT, PERIOD, counters and pending flags = 0
  - rdata = 00h
  - nint = 1
- rdata is updated on the edge where rd=1, is valid the following cycle, and holds until the next rd.
- nint is updated one cycle after the pending change.
- Simultaneous events:
  - Control write + tick, same timer, same cycle: the write wins. The counter loads PERIOD and the tick is discarded.
  - Status read + expiry, same cycle: the set wins and pending stays 1. rdata shows the pre-update value, so the event is reported on the next read and never lost.
  - wr and rd in the same cycle: both take effect; they target different registers by address semantics.
- Period wrap: count is 6-bit and never underflows. PERIOD=0 expires on every tick.
- A reset assertion mid-count returns everything to reset values immediately (asynchronous). nint deasserts without waiting for a clock.

## Structure
- wts_timer_pkg holds:
  - Address constants: ADR_T1_CTRL=0, ADR_T1_STAT=1, ADR_T2_CTRL=2, ADR_T2_STAT=3
  - Control bit positions: CTRL_EN=7, CTRL_ONESHOT=6, PERIOD field 5:0
  - STATUS_IDLE=8'h80
- Sub-module wts_timer_channel, instantiated twice:
  - Inputs: clk, nreset, tick, ctrl_we, wdata, stat_re
  - Outputs: ctrl, pending, en
- The top-level wts_timer does address decode, the rdata mux/register and nint.

## Test plan
- Reset, no ticks → both statuses read 80h; nint=1 throughout.
- Write 0C0h (EN, ONESHOT, PERIOD=0) to addresses 0 and 2, one tick → nint=0 within 2 cycles. Reading 1 returns 00h, then reading 3 returns 00h. nint=1 after the second read. Subsequent reads of 1 and 3 return 80h.
- Write 83h (periodic, PERIOD=3) to address 0, 12 ticks with a status read after each expiry → expiry on ticks 4, 8 and 12. Each status read returns 40h. A read between expiries returns C0h.
- Write 85h to address 2, then 3 ticks, then write 00h → no expiry over 20 further ticks. Reading 3 returns 80h.
- Status read of timer 1 coincident with its expiring tick → rdata=C0h (pre-update), nint stays 0, and the next read returns 40h.
- Control write coincident with a tick; nreset pulsed mid-count while pending=1 → the counter restarts at PERIOD. After reset, nint=1 immediately and statuses read 80h.
